// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, scanner states, matrix map and
// small decode helpers. The charge controller imports the same constants.
package keypad_pkg;

  localparam logic [3:0] KEY_START     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_CONFIRM   = 4'hC;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  // Key code for row r, column c of the 4x4 matrix.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_START;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_CLEAR;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_CONFIRM;
      4'hC: code = 4'hD;
      4'hD: code = 4'h0;
      4'hE: code = 4'hE;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    casez (rows)
      4'b???0: r = 2'd0;
      4'b??01: r = 2'd1;
      4'b?011: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Index of the single low bit of a one-hot-low column drive.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] c;
    case (col)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser whose flops reset to all ones (idle pulled-up rows).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // Two register stages; synchronous active-high reset to ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce
// and key-code mapping. Optional auto-repeat while a key is held is enabled
// by defining KEYPAD_AUTOREPEAT_EN. Note rst_n is active-high.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 5,
  parameter int DEBOUNCE_CNT  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       press,
  output logic       key_down
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  // Zero-length scan or debounce windows would break the FSM timing.
  if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_scanner: timing parameters must be >= 1");
  end

  logic [3:0]    row_s;
  state_t        state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [1:0]    r_idx;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_WRAP   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY);
  logic [RW-1:0] rep_cnt;
`endif

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk  (clk),
    .rst  (rst_n),
    .din  (row),
    .dout (row_s)
  );

  // Scan/debounce FSM with registered column drive and key outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= SCAN;
      col       <= 4'b1110;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      r_idx     <= 2'd0;
      key_value <= 4'h0;
      press     <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      press <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (row_s != 4'hF) begin
              // Column stays put; lowest low row is the candidate key.
              r_idx  <= low_row(row_s);
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              col <= {col[2:0], col[3]};
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s[r_idx]) begin
            // Glitch: rescan the same column from the start.
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_value <= map_key(r_idx, col_index(col));
            press     <= 1'b1;
            key_down  <= 1'b1;
            db_cnt    <= '0;
            state     <= HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (row_s[r_idx]) begin
            db_cnt <= '0;
            state  <= RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
            if (rep_cnt == REP_FIRST || rep_cnt == REP_WRAP) press <= 1'b1;
            rep_cnt <= (rep_cnt == REP_WRAP) ? REP_RELOAD : rep_cnt + 1'b1;
`endif
          end
        end
        RELEASE: begin
          if (!row_s[r_idx]) begin
            // Release bounce: still the same key-down, no new strobe.
            state <= HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (db_cnt == DB_LAST) begin
            key_down <= 1'b0;
            col      <= {col[2:0], col[3]};
            scan_cnt <= '0;
            db_cnt   <= '0;
            state    <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Optional auto-repeat steps run when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       press;
  logic       key_down;

  logic [3:0][3:0] keys;   // keys[r][c] = 1 when that key is closed

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int cyc = 0;
  int press_cyc[$];
  logic prev_press = 1'b0;
  logic dbl = 1'b0;
  int base;
  int first;

  keypad_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_value (key_value),
    .press     (press),
    .key_down  (key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Matrix model: a closed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col[c]) row[r] = 1'b0;
  end

  // Press monitor: count strobes, note their cycle, flag back-to-back pulses.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (press) begin
      n_press <= n_press + 1;
      press_cyc.push_back(cyc);
      if (prev_press) dbl <= 1'b1;
    end
    prev_press <= press;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a fresh arrival of the scan at column target (bounded).
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col == target && n < 100) begin step(1); n++; end
    while (col != target && n < 100) begin step(1); n++; end
    check("wait_col", {28'd0, col}, {28'd0, target});
  endtask

  initial begin
    keys  = '0;
    rst_n = 1'b1;
    step(2);
    rst_n = 1'b0;

    // Reset state
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_key_value", {28'd0, key_value}, 32'h0);
    check("rst_press", {31'd0, press}, 32'h0);
    check("rst_key_down", {31'd0, key_down}, 32'h0);

    // Idle scan: each column for 5 cycles, wrapping after column 3
    for (int i = 0; i < 40; i++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((i / 5) % 4));
      check($sformatf("idle_col[%0d]", i), {28'd0, col}, {28'd0, exp_col});
      step(1);
    end
    check("idle_no_press", n_press, 0);
    check("idle_key_value", {28'd0, key_value}, 32'h0);

    // Key 8 (r2,c1) held 100 cycles, then released
    base = n_press;
    keys[2][1] = 1'b1;
    step(100);
    check("k8_one_press", n_press - base, 1);
    check("k8_value", {28'd0, key_value}, 32'h8);
    check("k8_key_down", {31'd0, key_down}, 32'h1);
    keys[2][1] = 1'b0;
    step(20);
    check("k8_down_during_release", {31'd0, key_down}, 32'h1);
    step(5);
    check("k8_released", {31'd0, key_down}, 32'h0);
    check("k8_no_extra_press", n_press - base, 1);

    // 10-cycle glitch on r3,c1: rejected, scan resumes in column 1
    wait_col(4'b1101);
    base = n_press;
    keys[3][1] = 1'b1;
    step(10);
    keys[3][1] = 1'b0;
    step(4);
    check("glitch_col_held", {28'd0, col}, 32'hD);
    step(30);
    check("glitch_no_press", n_press - base, 0);
    check("glitch_key_down", {31'd0, key_down}, 32'h0);
    check("glitch_value_kept", {28'd0, key_value}, 32'h8);

    // Confirm (r2,c3) with three 5-cycle release bounces
    base = n_press;
    keys[2][3] = 1'b1;
    step(80);
    check("conf_press", n_press - base, 1);
    check("conf_value", {28'd0, key_value}, 32'hC);
    for (int b = 0; b < 3; b++) begin
      keys[2][3] = 1'b0;
      step(5);
      keys[2][3] = 1'b1;
      step(5);
    end
    check("conf_bounce_down", {31'd0, key_down}, 32'h1);
    check("conf_bounce_no_press", n_press - base, 1);
    keys[2][3] = 1'b0;
    step(40);
    check("conf_released", {31'd0, key_down}, 32'h0);
    check("conf_single_press", n_press - base, 1);

    // Rows 0 and 2 in column 0: lowest row wins; column-2 key locked out
    base = n_press;
    keys[0][0] = 1'b1;
    keys[2][0] = 1'b1;
    step(80);
    check("multi_press", n_press - base, 1);
    check("multi_value", {28'd0, key_value}, 32'h1);
    keys[1][2] = 1'b1;
    step(60);
    check("lockout_no_press", n_press - base, 1);
    check("lockout_value", {28'd0, key_value}, 32'h1);
    check("lockout_key_down", {31'd0, key_down}, 32'h1);
    keys = '0;
    step(40);
    check("multi_released", {31'd0, key_down}, 32'h0);

    // Reset mid-press: outputs clear, held key must be re-debounced
    base = n_press;
    keys[0][0] = 1'b1;
    step(80);
    check("rstmid_pre_press", n_press - base, 1);
    rst_n = 1'b1;
    step(1);
    rst_n = 1'b0;
    check("rstmid_col", {28'd0, col}, 32'hE);
    check("rstmid_key_value", {28'd0, key_value}, 32'h0);
    check("rstmid_press", {31'd0, press}, 32'h0);
    check("rstmid_key_down", {31'd0, key_down}, 32'h0);
    base = n_press;
    step(20);
    check("rstmid_no_early_press", n_press - base, 0);
    step(20);
    check("rstmid_repress", n_press - base, 1);
    check("rstmid_value", {28'd0, key_value}, 32'h1);
    keys = '0;
    step(40);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Hold key 5: strobes at accept, +500, +700
    base = press_cyc.size();
    keys[1][1] = 1'b1;
    for (int n = 0; n < 100 && press_cyc.size() == base; n++) step(1);
    check("rep_accept", press_cyc.size() - base, 1);
    step(850);
    check("rep_count", press_cyc.size() - base, 3);
    if (press_cyc.size() - base == 3) begin
      first = press_cyc[base];
      check("rep_first_gap", press_cyc[base + 1] - first, 500);
      check("rep_second_gap", press_cyc[base + 2] - first, 700);
    end
    check("rep_value", {28'd0, key_value}, 32'h5);
    rst_n = 1'b1;
    step(1);
    rst_n = 1'b0;
    check("rep_rst_value", {28'd0, key_value}, 32'h0);
    check("rep_rst_press", {31'd0, press}, 32'h0);
    check("rep_rst_col", {28'd0, col}, 32'hE);
    keys = '0;
    step(10);
`endif

    check("no_back_to_back_press", {31'd0, dbl}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
